// File: rtl/rgb_sinp.sv
// WS2812B single-wire decoder: measures each high pulse, assembles 24-bit G-R-B words
// and stream-reset markers, and pushes them into the RGBW output FIFO.
module rgb_sinp #(
   parameter int T1_THRESH_CLKS    = 58,
   parameter int GLITCH_CLKS       = 8,
   parameter int MAX_HIGH_CLKS     = 192,
   parameter int STREAM_RESET_CLKS = 4800,
   parameter int COUNTER_MAX       = 8000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_sig,
   input  logic        in_wr_fifo_full,
   output logic        out_wr_fifo_en,
   output logic [31:0] out_wr_fifo_data,
   output logic        out_overflow,
   output logic        out_line_err
);

   localparam int CNT_W = $clog2(COUNTER_MAX + 1);

   typedef enum logic [1:0] {S_LOW, S_HIGH, S_ERR} state_t;

   state_t           state, nxt_state;
   logic             sync_p0, sig_s, sig_d;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       bit_cnt;
   logic [23:0]      shreg;
   logic             arm;
   logic             word_done;
   logic             vld_p1;
   logic [31:0]      word_p1;

   // Comb decisions from the FSM
   logic do_shift, bit_val, clr_bits, set_arm, clr_arm, set_err, issue_mrk;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= CNT_W'(COUNTER_MAX))
         return CNT_W'(COUNTER_MAX);
      return v + 1'b1;
   endfunction

   assign rise      = sig_s & ~sig_d;
   assign fall      = ~sig_s & sig_d;
   assign word_done = (bit_cnt == 5'd24);

   // Input synchronizer and edge-detect delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sig_s   <= 1'b0;
         sig_d   <= 1'b0;
      end else begin
         sync_p0 <= in_sig;
         sig_s   <= sync_p0;
         sig_d   <= sig_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (rise || fall)
         cnt <= CNT_W'(1);
      else
         cnt <= sat_inc(cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_LOW;
      else
         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      do_shift  = 1'b0;
      bit_val   = 1'b0;
      clr_bits  = 1'b0;
      set_arm   = 1'b0;
      clr_arm   = 1'b0;
      set_err   = 1'b0;
      issue_mrk = 1'b0;
      case (state)
         S_LOW: begin
            if (cnt == CNT_W'(STREAM_RESET_CLKS) && arm) begin
               issue_mrk = 1'b1;
               clr_bits  = 1'b1;
               clr_arm   = 1'b1;
            end
            if (rise)
               nxt_state = S_HIGH;
         end
         S_HIGH: begin
            if (fall) begin
               nxt_state = S_LOW;
               if (cnt >= CNT_W'(MAX_HIGH_CLKS)) begin
                  set_err  = 1'b1;
                  clr_bits = 1'b1;
                  set_arm  = 1'b1;
               end else if (cnt >= CNT_W'(GLITCH_CLKS)) begin
                  do_shift = 1'b1;
                  bit_val  = (cnt >= CNT_W'(T1_THRESH_CLKS));
                  set_arm  = 1'b1;
               end
            end else if (cnt >= CNT_W'(MAX_HIGH_CLKS)) begin
               // Over-long pulse: flag it and swallow the rest of the high time
               set_err   = 1'b1;
               clr_bits  = 1'b1;
               set_arm   = 1'b1;
               nxt_state = S_ERR;
            end
         end
         S_ERR: begin
            if (fall)
               nxt_state = S_LOW;
         end
         default: nxt_state = S_LOW;
      endcase
   end

   // Bit assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
         arm     <= 1'b0;
      end else begin
         if (clr_bits || word_done)
            bit_cnt <= '0;
         else if (do_shift)
            bit_cnt <= bit_cnt + 5'd1;
         if (do_shift)
            shreg <= {shreg[22:0], bit_val};
         if (clr_arm)
            arm <= 1'b0;
         else if (set_arm)
            arm <= 1'b1;
      end
   end

   // p1: word/marker request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         word_p1 <= '0;
      end else begin
         vld_p1 <= word_done | issue_mrk;
         if (issue_mrk)
            word_p1 <= {2'b01, 30'd0};
         else if (word_done)
            word_p1 <= {8'h80, shreg};
      end
   end

   // p2: FIFO write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_wr_fifo_en   <= 1'b0;
         out_wr_fifo_data <= '0;
         out_overflow     <= 1'b0;
         out_line_err     <= 1'b0;
      end else begin
         out_wr_fifo_en <= vld_p1 & ~in_wr_fifo_full;
         if (vld_p1 && !in_wr_fifo_full)
            out_wr_fifo_data <= word_p1;
         if (vld_p1 && in_wr_fifo_full)
            out_overflow <= 1'b1;
         if (set_err)
            out_line_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rgb_sinp.sv
// Scoreboard bench for rgb_sinp: expected FIFO words are queued as stimulus is sent
// and matched against every write the decoder issues.
module tb_rgb_sinp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_sig = 1'b0;
   logic        in_wr_fifo_full = 1'b0;
   logic        out_wr_fifo_en;
   logic [31:0] out_wr_fifo_data;
   logic        out_overflow;
   logic        out_line_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   logic [31:0] exp_q[$];

   rgb_sinp dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_sig           (in_sig),
      .in_wr_fifo_full  (in_wr_fifo_full),
      .out_wr_fifo_en   (out_wr_fifo_en),
      .out_wr_fifo_data (out_wr_fifo_data),
      .out_overflow     (out_overflow),
      .out_line_err     (out_line_err)
   );

   always #5 clk = ~clk;

   // Write monitor: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n && out_wr_fifo_en) begin
         logic [31:0] e;
         n_writes++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got %08h, required no write", out_wr_fifo_data);
         end else begin
            e = exp_q.pop_front();
            if (out_wr_fifo_data !== e) begin
               n_fail++;
               $display("FAIL write_data: got %08h, required %08h", out_wr_fifo_data, e);
            end
         end
      end
   end

   // All drives happen 1 time unit after a rising edge
   task automatic pulse(input int h);
      in_sig = 1'b1;
      repeat (h) @(posedge clk);
      #1 in_sig = 1'b0;
   endtask

   task automatic gap(input int l);
      repeat (l) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      int h;
      h = b ? 77 : 38;
      pulse(h);
      gap(120 - h);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected writes missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_line_err} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b data=%08h ovf=%b err=%b, required all 0",
                  out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_line_err);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      // Unarmed idle line past the stream-reset time must not produce a marker
      gap(5000);
      n_checks++;
      if (n_writes != 0) begin
         n_fail++;
         $display("FAIL idle_no_marker: got %0d writes, required 0", n_writes);
      end
   endtask

   task automatic test_basic;
      logic [23:0] w;
      w = 24'h00FF00;
      exp_q.push_back(32'h8000FF00);
      for (int i = 23; i >= 1; i--) send_bit(w[i]);
      pulse(38);
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (out_wr_fifo_en !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: got en=%b, required 0", out_wr_fifo_en);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_wr_fifo_en !== 1'b1 || out_wr_fifo_data !== 32'h8000FF00) begin
         n_fail++;
         $display("FAIL latency_4clk: got en=%b data=%08h, required en=1 data=8000ff00",
                  out_wr_fifo_en, out_wr_fifo_data);
      end
      gap(120 - 38 - 5);
      check_drained("basic_drain");
   endtask

   task automatic test_back_to_back;
      int w0;
      exp_q.push_back(32'h80123456);
      exp_q.push_back(32'h80ABCDEF);
      send_word(24'h123456);
      send_word(24'hABCDEF);
      exp_q.push_back(32'h40000000);
      gap(5760);
      check_drained("marker_drain");
      w0 = n_writes;
      gap(19200);
      n_checks++;
      if (n_writes != w0) begin
         n_fail++;
         $display("FAIL single_marker: got %0d extra writes, required 0", n_writes - w0);
      end
   endtask

   task automatic test_partial;
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      exp_q.push_back(32'h40000000);
      gap(5760);
      exp_q.push_back(32'h80FFFFFF);
      send_word(24'hFFFFFF);
      check_drained("partial_drain");
   endtask

   task automatic test_boundary;
      // bit5 and bit20 are 58-clk ones; bit3 is 57 clk (0); bit10 is 8 clk (0)
      exp_q.push_back(32'h80040008);
      for (int i = 0; i < 24; i++) begin
         if (i == 3) begin
            pulse(57); gap(63);
         end else if (i == 5 || i == 20) begin
            pulse(58); gap(62);
         end else if (i == 10) begin
            pulse(8); gap(112);
         end else begin
            send_bit(1'b0);
         end
         if (i == 7) begin
            pulse(5); gap(60);
         end
      end
      check_drained("boundary_drain");
   endtask

   task automatic test_fifo_full;
      logic [23:0] w;
      w = 24'h0000FF;
      for (int i = 23; i >= 1; i--) send_bit(w[i]);
      pulse(77);
      in_wr_fifo_full = 1'b1;
      gap(10);
      in_wr_fifo_full = 1'b0;
      gap(33);
      n_checks++;
      if (out_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_set: got %b, required 1", out_overflow);
      end
      exp_q.push_back(32'h80C0FFEE);
      send_word(24'hC0FFEE);
      check_drained("after_full_drain");
      n_checks++;
      if (out_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky: got %b, required 1", out_overflow);
      end
   endtask

   task automatic test_line_err;
      n_checks++;
      if (out_line_err !== 1'b0) begin
         n_fail++;
         $display("FAIL line_err_clear: got %b, required 0", out_line_err);
      end
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      pulse(250);
      gap(100);
      n_checks++;
      if (out_line_err !== 1'b1) begin
         n_fail++;
         $display("FAIL line_err_set: got %b, required 1", out_line_err);
      end
      exp_q.push_back(32'h80A5A55A);
      send_word(24'hA5A55A);
      check_drained("after_err_drain");
   endtask

   task automatic test_reset_midword;
      int w0;
      w0 = n_writes;
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      in_sig = 1'b1;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_line_err} !== 35'd0) begin
         n_fail++;
         $display("FAIL async_reset: got en=%b data=%08h ovf=%b err=%b, required all 0",
                  out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_line_err);
      end
      in_sig = 1'b0;
      gap(5);
      rst_n = 1'b1;
      gap(200);
      n_checks++;
      if (n_writes != w0) begin
         n_fail++;
         $display("FAIL midword_lost: got %0d writes, required 0", n_writes - w0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_partial();
      test_boundary();
      test_fifo_full();
      test_line_err();
      test_reset_midword();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_sinp.md
Name: rgb_sinp

Overview:
- WS2812B serial input decoder running at 96 MHz.
- Synchronizes the single-wire LED data line and measures each high pulse to decide whether it is a 0 or 1 bit.
- Assembles 24 bits (G-R-B, MSB first) into a status+data word and writes it into the write side of the FIFO feeding the RGBW output path.
- Detects the stream-reset low period and writes a reset-marker word so the output side can reproduce the reset.

Parameters:
T1_THRESH_CLKS, 58, a high pulse of at least this many clocks decodes as bit 1; shorter decodes as bit 0 (~0.6 us at 96 MHz).
GLITCH_CLKS, 8, a high pulse shorter than this is ignored entirely.
MAX_HIGH_CLKS, 192, a high pulse reaching this length is a line error (~2 us).
STREAM_RESET_CLKS, 4800, this many consecutive low clocks is a stream reset (~50 us).
COUNTER_MAX, 8000, saturation value of the pulse counter; width = $clog2(COUNTER_MAX+1).

Ports:
clk  input  1  96 MHz clock, synchronous with FIFO w_clk
rst_n  input  1  asynchronous, active-low reset
in_sig  input  1  raw WS2812B serial line (asynchronous)
in_wr_fifo_full  input  1  FIFO write-full flag
out_wr_fifo_en  output  1  FIFO write enable, one-clock pulse
out_wr_fifo_data  output  32  FIFO write data, valid while out_wr_fifo_en=1
out_overflow  output  1  sticky: a word was dropped because the FIFO was full
out_line_err  output  1  sticky: a high pulse reached MAX_HIGH_CLKS

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; synchronizer flops 0; counter 0; bit count 0; shift register 0.
  - Reset-marker arm flag 0; state S_LOW.
- Input conditioning:
  - in_sig passes through 2 flops to give sig_s, then 1 more flop to give sig_d.
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
- Counter:
  - Cleared to 1 on any edge; otherwise increments each clock.
  - Saturates at COUNTER_MAX.
- State S_LOW:
  - On rise: go to S_HIGH.
  - When the counter equals STREAM_RESET_CLKS and arm=1, for one clock:
    - Discard the partial word: bit count <= 0.
    - Issue a reset-marker write.
    - Set arm <= 0.
- State S_HIGH:
  - On fall with counter < GLITCH_CLKS: ignore the pulse (no bit), go to S_LOW.
  - On fall otherwise:
    - Decoded bit = (counter >= T1_THRESH_CLKS).
    - Shift it into the LSB of a 24-bit shift register; increment bit count; set arm <= 1; go to S_LOW.
  - If the counter reaches MAX_HIGH_CLKS:
    - Set out_line_err; clear bit count; set arm <= 1.
    - Go to S_ERR.
- State S_ERR:
  - Wait for fall, then go to S_LOW. No bit is decoded from this pulse.
- Word completion:
  - When the 24th bit is shifted in, the data word is written on the next clock and bit count returns to 0.
  - Data word = {1'b1 valid, 1'b0 stream_reset, 6'b0, G[23:16], R[15:8], B[7:0]}. The first received bit lands in bit 23.
  - Reset-marker word = {1'b0, 1'b1, 30'b0}.
- Latency and write rules:
  - out_wr_fifo_en rises 4 clocks after the first clk edge that samples in_sig low on the 24th bit's falling edge: 2 sync + 1 detect + 1 register.
  - Data stays stable while enable is high. Never two writes on consecutive clocks.
- FIFO full:
  - If in_wr_fifo_full=1 in the cycle a write would issue, no write occurs, the word is dropped, and out_overflow is set.
  - Decoding continues normally.
  - out_overflow and out_line_err clear only on reset.
- Arm flag:
  - At power-up it is 0, so an idle-low line produces no marker.
  - Exactly one marker is produced per qualifying low run, however long the run lasts.
- Boundaries:
  - A low run of exactly STREAM_RESET_CLKS-1 clocks produces no marker.
  - A high pulse of exactly T1_THRESH_CLKS-1 clocks decodes as 0; exactly T1_THRESH_CLKS decodes as 1.
  - A high pulse of exactly GLITCH_CLKS clocks is a valid 0 bit.
  - A rise in the same cycle the counter hits STREAM_RESET_CLKS: the marker is still issued, then S_HIGH is entered.
- Reset mid-word: the partial word is lost and nothing is written.

Test Plan:
- Send 24 bits of 0x00FF00 (G=0x00, R=0xFF, B=0x00) with T0H=38 clk, T1H=77 clk, 120-clk period -> exactly one write of 0x8000FF00, 4 clocks after the last fall.
- Send two words 0x123456 and 0xABCDEF, then 60 us low -> writes 0x80123456, 0x80ABCDEF, 0x40000000; no further write during 200 us of additional low.
- Send 10 bits, then 60 us low, then 24 bits of 0xFFFFFF -> one 0x40000000 write, then 0x80FFFFFF; the 10-bit partial word is never written.
- Boundary pulses 57/58 clk high and a 5-clk glitch among 24 otherwise-0 bits -> bits decode 0/1, the glitch adds no bit, and the word matches the expected value.
- Hold in_wr_fifo_full=1 during the write of 0x0000FF -> no out_wr_fifo_en and out_overflow=1; the next word writes normally and out_overflow stays 1 until rst_n=0.
- 250-clk high pulse after 5 bits -> out_line_err=1, no write, next full 24 bits write correctly; assert rst_n=0 mid-word -> all outputs 0 immediately (asynchronous).
